// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg
// Shared definitions for the instruction fetch unit:
//   - instruction-encoding macros that map an opcode byte to its immediate class
//   - fetch FSM state type
//   - instruction-length constants
// Ports: none (package).

`ifndef INSTR_FETCH_ENC_DEFS
`define INSTR_FETCH_ENC_DEFS
// Opcode bits [7:6] select the immediate class. Inside the 32-bit class,
// bit 5 selects a full-word immediate (1 + WORD_WIDTH/8 bytes) instead.
`define IF_OPC_CLASS(op)  op[7:6]
`define IF_OPC_WIDE(op)   op[5]
`define IF_CLASS_IMM0     2'b00
`define IF_CLASS_IMM8     2'b01
`define IF_CLASS_IMM16    2'b10
`define IF_CLASS_IMM32    2'b11
`endif

package instr_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [3:0] LEN_IMM0  = 4'd1;
  localparam logic [3:0] LEN_IMM8  = 4'd2;
  localparam logic [3:0] LEN_IMM16 = 4'd3;
  localparam logic [3:0] LEN_IMM32 = 4'd5;

endpackage

// File: rtl/instr_fetch_length.sv
// instr_length_decode
// Combinational opcode-to-length decoder built on the shared encoding macros.
// Ports:
//   opcode [7:0] : opcode byte at the head of the fetch queue
//   len    [3:0] : total instruction length in bytes (opcode + immediate)

module instr_length_decode
  import instr_fetch_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic [7:0] opcode,
  output logic [3:0] len
);

  localparam logic [3:0] LEN_IMMW = 4'(1 + WORD_WIDTH / 8);

  // Low opcode bits carry no length information.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^opcode[4:0];

  always_comb begin
    len = LEN_IMM0;
    case (`IF_OPC_CLASS(opcode))
      `IF_CLASS_IMM0:  len = LEN_IMM0;
      `IF_CLASS_IMM8:  len = LEN_IMM8;
      `IF_CLASS_IMM16: len = LEN_IMM16;
      `IF_CLASS_IMM32: len = `IF_OPC_WIDE(opcode) ? LEN_IMMW : LEN_IMM32;
      default:         len = LEN_IMM0;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
// Instruction fetch unit: reads whole words from program memory into a byte
// queue and presents variable-length instructions (opcode + immediate).
// Optional feature: define INSTR_FETCH_PERF_EN to add the stall_count output.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   pm_req/pm_addr/pm_ack        : program memory read request (one outstanding)
//   pm_rvalid/pm_rdata           : read response, byte 0 in bits [7:0]
//   instr_valid/instr_ready      : instruction handshake
//   instr_pc/opcode/imm/instr_len: presented instruction
//   redirect/redirect_pc         : flush and restart fetching at redirect_pc
//   stall_count (optional)       : cycles with ready high but nothing to hand out

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int WORD_WIDTH         = 32,
  parameter int PROGRAM_ADDR_WIDTH = 16,
  parameter logic [PROGRAM_ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          pm_req,
  output logic [PROGRAM_ADDR_WIDTH-1:0] pm_addr,
  input  logic                          pm_ack,
  input  logic                          pm_rvalid,
  input  logic [WORD_WIDTH-1:0]         pm_rdata,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [PROGRAM_ADDR_WIDTH-1:0] instr_pc,
  output logic [7:0]                    opcode,
  output logic [WORD_WIDTH-1:0]         imm,
  output logic [3:0]                    instr_len,
  input  logic                          redirect,
  input  logic [PROGRAM_ADDR_WIDTH-1:0] redirect_pc
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0]                   stall_count
`endif
);

  localparam int WB     = WORD_WIDTH / 8;
  localparam int QBYTES = 2 * WB + 4;
  localparam int CW     = $clog2(QBYTES + 1);
  localparam int IW     = $clog2(QBYTES);
  localparam int PAW    = PROGRAM_ADDR_WIDTH;

  localparam logic [PAW-1:0] WB_ADDR     = PAW'(WB);
  localparam logic [PAW-1:0] RESET_OFF   = RESET_PC % WB_ADDR;
  localparam logic [PAW-1:0] RESET_FETCH = RESET_PC - RESET_OFF;

  fetch_state_t   state, state_next;
  logic [7:0]     q      [QBYTES];
  logic [7:0]     q_next [QBYTES];
  logic [CW-1:0]  count, count_next, base, pop_len, free_after, skip;
  logic [PAW-1:0] fetch_addr, redirect_off;
  logic [3:0]     dec_len;
  logic           has_byte, pop, push;

  instr_length_decode #(.WORD_WIDTH(WORD_WIDTH)) u_len (
    .opcode (q[0]),
    .len    (dec_len)
  );

  // Instruction view of the queue head; everything reads 0 while empty.
  always_comb begin
    has_byte    = (count != '0);
    instr_len   = has_byte ? dec_len : 4'd0;
    opcode      = has_byte ? q[0] : 8'd0;
    instr_valid = has_byte && (count >= CW'(dec_len));
    imm         = '0;
    for (int k = 0; k < WB; k++) begin
      if (instr_valid && ((k + 1) < int'(dec_len))) imm[8*k +: 8] = q[k+1];
    end
    pop          = instr_valid && instr_ready && !redirect;
    pop_len      = pop ? CW'(dec_len) : '0;
    free_after   = CW'(QBYTES) - count + pop_len;
    redirect_off = redirect_pc % WB_ADDR;
  end

  assign pm_addr = fetch_addr;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // A redirect in S_WAIT leaves a read in flight whose data must be dropped,
  // so it goes through S_DRAIN; a redirect coinciding with the response
  // simply discards it.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (pm_req && pm_ack) state_next = S_WAIT;
      S_WAIT: begin
        if (pm_rvalid)     state_next = S_IDLE;
        else if (redirect) state_next = S_DRAIN;
      end
      S_DRAIN: if (pm_rvalid) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // A request is only raised when a full word fits after this cycle's pop,
  // so the slot stays reserved until the response arrives.
  always_comb begin
    pm_req = 1'b0;
    push   = 1'b0;
    case (state)
      S_IDLE:  pm_req = !reset && !redirect && (free_after >= CW'(WB));
      S_WAIT:  push   = pm_rvalid && !redirect;
      default: ;
    endcase
  end

  // Pop shifts the queue down by the instruction length; push appends the
  // word after the surviving bytes, dropping the leading bytes that precede
  // an unaligned restart address.
  always_comb begin
    int src;
    int dst;
    src  = 0;
    dst  = 0;
    base = count - pop_len;
    for (int i = 0; i < QBYTES; i++) begin
      q_next[i] = 8'd0;
      src = i + int'(pop_len);
      if (src < QBYTES) q_next[i] = q[IW'(src)];
    end
    if (push) begin
      for (int j = 0; j < WB; j++) begin
        if (j >= int'(skip)) begin
          dst = int'(base) + j - int'(skip);
          if (dst < QBYTES) q_next[IW'(dst)] = pm_rdata[8*j +: 8];
        end
      end
    end
    count_next = base + (push ? (CW'(WB) - skip) : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q          <= '{default: '0};
      count      <= '0;
      instr_pc   <= RESET_PC;
      fetch_addr <= RESET_FETCH;
      skip       <= CW'(RESET_OFF);
    end else if (redirect) begin
      count      <= '0;
      instr_pc   <= redirect_pc;
      fetch_addr <= redirect_pc - redirect_off;
      skip       <= CW'(redirect_off);
    end else begin
      q     <= q_next;
      count <= count_next;
      if (pop) instr_pc <= instr_pc + PAW'(dec_len);
      if (push) begin
        fetch_addr <= fetch_addr + WB_ADDR;
        skip       <= '0;
      end
    end
  end

`ifdef INSTR_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (instr_ready && !instr_valid && !redirect && (stall_count != '1)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
// Randomized bench for instr_fetch with a program-memory model and an
// instruction-stream reference model (expected opcode/imm/length computed
// from memory contents at the architectural PC).

module tb_instr_fetch;

  localparam int WW     = 32;
  localparam int PAW    = 16;
  localparam int WBYTES = WW / 8;

  logic            clk = 1'b0;
  logic            reset, pm_req, pm_ack, pm_rvalid;
  logic            instr_valid, instr_ready, redirect;
  logic [PAW-1:0]  pm_addr, instr_pc, redirect_pc;
  logic [WW-1:0]   pm_rdata, imm;
  logic [7:0]      opcode;
  logic [3:0]      instr_len;
`ifdef INSTR_FETCH_PERF_EN
  logic [31:0]     stall_count;
  logic [31:0]     exp_stall;
`endif

  always #5 clk = ~clk;

  instr_fetch #(
    .WORD_WIDTH(WW),
    .PROGRAM_ADDR_WIDTH(PAW),
    .RESET_PC(16'h0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pm_req(pm_req),
    .pm_addr(pm_addr),
    .pm_ack(pm_ack),
    .pm_rvalid(pm_rvalid),
    .pm_rdata(pm_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_pc(instr_pc),
    .opcode(opcode),
    .imm(imm),
    .instr_len(instr_len),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
`ifdef INSTR_FETCH_PERF_EN
    ,
    .stall_count(stall_count)
`endif
  );

  int check_count = 0;
  int error_count = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] model_pc;
  bit          mem_busy;
  logic [15:0] mem_addr;
  int          mem_delay;
  int          ack_pct, lat_min, lat_max;
  bit          stray_resp;
  int          resp_total, hs_total;
  bit          prev_pending;
  logic [15:0] prev_addr;
  bit          last_valid, last_req;

  logic [15:0] req_log [$];
  logic [15:0] hs_pc   [$];
  logic [7:0]  hs_op   [$];
  logic [3:0]  hs_len  [$];
  logic [31:0] hs_imm  [$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction length straight from the encoding rules.
  function automatic int refLenOf(input logic [7:0] op);
    case (op[7:6])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 3;
      default: return op[5] ? 1 + WBYTES : 5;
    endcase
  endfunction

  task automatic clearLogs();
    req_log.delete();
    hs_pc.delete();
    hs_op.delete();
    hs_len.delete();
    hs_imm.delete();
  endtask

  // One clock cycle: drive inputs, model memory, check the instruction stream.
  task automatic applyStimulus(input bit do_redir, input logic [15:0] rpc, input bit rdy);
    logic [7:0]  ref_op;
    int          ref_len;
    logic [31:0] ref_imm;
    logic [15:0] a;
    @(negedge clk);
    reset       = 1'b0;
    redirect    = do_redir;
    redirect_pc = rpc;
    instr_ready = rdy;
    pm_ack      = ($urandom_range(0, 99) < ack_pct);
    if (stray_resp) begin
      pm_rvalid  = 1'b1;
      pm_rdata   = $urandom;
      stray_resp = 1'b0;
    end else if (mem_busy && mem_delay == 0) begin
      pm_rvalid = 1'b1;
      for (int k = 0; k < WBYTES; k++) begin
        a = mem_addr + 16'(k);
        pm_rdata[8*k +: 8] = mem[a];
      end
    end else begin
      pm_rvalid = 1'b0;
      pm_rdata  = $urandom;
    end
    #1;
    last_valid = instr_valid;
    last_req   = pm_req;
    if (pm_req) begin
      checkOutput("pm_addr_align", 64'(pm_addr % WBYTES), 64'd0);
      checkOutput("single_outstanding", 64'(mem_busy), 64'd0);
    end
    if (prev_pending) begin
      if (do_redir) begin
        checkOutput("req_drop_on_redirect", 64'(pm_req), 64'd0);
      end else begin
        checkOutput("req_hold", 64'(pm_req), 64'd1);
        checkOutput("addr_hold", 64'(pm_addr), 64'(prev_addr));
      end
    end
    prev_pending = pm_req && !pm_ack;
    prev_addr    = pm_addr;

    if (instr_valid && rdy && !do_redir) begin
      ref_op  = mem[model_pc];
      ref_len = refLenOf(ref_op);
      ref_imm = '0;
      for (int k = 1; k < ref_len; k++) begin
        a = model_pc + 16'(k);
        ref_imm = ref_imm | (32'(mem[a]) << (8 * (k - 1)));
      end
      checkOutput("instr_pc", 64'(instr_pc), 64'(model_pc));
      checkOutput("opcode", 64'(opcode), 64'(ref_op));
      checkOutput("instr_len", 64'(instr_len), 64'(ref_len));
      checkOutput("imm", 64'(imm), 64'(ref_imm));
      hs_pc.push_back(instr_pc);
      hs_op.push_back(opcode);
      hs_len.push_back(instr_len);
      hs_imm.push_back(imm);
      hs_total++;
      model_pc = model_pc + 16'(ref_len);
    end
    if (do_redir) model_pc = rpc;

`ifdef INSTR_FETCH_PERF_EN
    checkOutput("stall_count", 64'(stall_count), 64'(exp_stall));
    if (rdy && !instr_valid && !do_redir) exp_stall = exp_stall + 32'd1;
`endif

    if (pm_rvalid) begin
      resp_total++;
      mem_busy = 1'b0;
    end else if (mem_busy) begin
      mem_delay--;
    end
    if (pm_req && pm_ack) begin
      mem_busy  = 1'b1;
      mem_addr  = pm_addr;
      mem_delay = $urandom_range(lat_min, lat_max);
      req_log.push_back(pm_addr);
    end
  endtask

  // Two reset cycles with a competing redirect and response in the first;
  // the cycle right after reset carries a stray response.
  task automatic applyReset();
    @(negedge clk);
    reset       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h1234;
    instr_ready = 1'b1;
    pm_ack      = 1'b1;
    pm_rvalid   = 1'b1;
    pm_rdata    = $urandom;
    @(negedge clk);
    redirect  = 1'b0;
    pm_rvalid = 1'b0;
    #1;
    checkOutput("rst_pm_req", 64'(pm_req), 64'd0);
    checkOutput("rst_instr_valid", 64'(instr_valid), 64'd0);
    checkOutput("rst_opcode", 64'(opcode), 64'd0);
    checkOutput("rst_imm", 64'(imm), 64'd0);
    checkOutput("rst_instr_len", 64'(instr_len), 64'd0);
`ifdef INSTR_FETCH_PERF_EN
    checkOutput("rst_stall_count", 64'(stall_count), 64'd0);
    exp_stall = '0;
`endif
    mem_busy     = 1'b0;
    model_pc     = 16'h0000;
    prev_pending = 1'b0;
    stray_resp   = 1'b1;
  endtask

  initial begin
    int n;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    pm_ack = 1'b0; pm_rvalid = 1'b0; pm_rdata = '0;
    mem_busy = 1'b0; mem_addr = '0; mem_delay = 0; stray_resp = 1'b0;
    resp_total = 0; hs_total = 0; prev_pending = 1'b0; prev_addr = '0;
    last_valid = 1'b0; last_req = 1'b0; model_pc = '0;
`ifdef INSTR_FETCH_PERF_EN
    exp_stall = '0;
`endif
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // Two instructions from word 0: IMM8 op with 0xAB, then a 1-byte op.
    mem[0] = 8'h40; mem[1] = 8'hAB; mem[2] = 8'h00;
    ack_pct = 100; lat_min = 0; lat_max = 0;
    applyReset();
    clearLogs();
    n = 0;
    while (hs_pc.size() < 2 && n < 30) begin applyStimulus(1'b0, 16'h0, 1'b1); n++; end
    checkOutput("t040_handshakes", 64'(hs_pc.size() >= 2), 64'd1);
    if (hs_pc.size() >= 2) begin
      checkOutput("t040_pc0", 64'(hs_pc[0]), 64'h0);
      checkOutput("t040_imm0", 64'(hs_imm[0]), 64'hAB);
      checkOutput("t040_len0", 64'(hs_len[0]), 64'd2);
      checkOutput("t040_pc1", 64'(hs_pc[1]), 64'h2);
      checkOutput("t040_len1", 64'(hs_len[1]), 64'd1);
    end

    // IMM32 opcode at byte 3 straddling two words, restarted from idle.
    mem[3] = 8'hC0; mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
    mem[8] = 8'h00;
    lat_min = 0; lat_max = 1;
    n = 0;
    do begin applyStimulus(1'b0, 16'h0, 1'b0); n++; end while (mem_busy && n < 20);
    checkOutput("t041_idle_reached", 64'(mem_busy), 64'd0);
    applyStimulus(1'b1, 16'h0003, 1'b1);
    clearLogs();
    begin
      int r0, pushes;
      r0 = resp_total;
      n = 0;
      while (hs_pc.size() == 0 && n < 30) begin
        pushes = resp_total - r0;
        applyStimulus(1'b0, 16'h0, 1'b1);
        if (pushes < 2) checkOutput("t041_early_valid", 64'(last_valid), 64'd0);
        n++;
      end
    end
    checkOutput("t041_handshake", 64'(hs_pc.size()), 64'd1);
    if (hs_pc.size() >= 1) begin
      checkOutput("t041_pc", 64'(hs_pc[0]), 64'h3);
      checkOutput("t041_len", 64'(hs_len[0]), 64'd5);
      checkOutput("t041_imm", 64'(hs_imm[0]), 64'h44332211);
    end

    // Redirect to 0x0006 while a read is outstanding.
    mem[6] = 8'h05;
    lat_min = 2; lat_max = 2;
    n = 0;
    do begin applyStimulus(1'b0, 16'h0, 1'b1); n++; end
      while (!(mem_busy && mem_delay > 0) && n < 30);
    checkOutput("t042_wait_reached", 64'(mem_busy), 64'd1);
    clearLogs();
    applyStimulus(1'b1, 16'h0006, 1'b1);
    n = 0;
    while (hs_pc.size() == 0 && n < 40) begin applyStimulus(1'b0, 16'h0, 1'b1); n++; end
    checkOutput("t042_handshake", 64'(hs_pc.size()), 64'd1);
    if (hs_pc.size() >= 1) begin
      checkOutput("t042_req_addr", 64'(req_log[0]), 64'h4);
      checkOutput("t042_pc", 64'(hs_pc[0]), 64'h6);
      checkOutput("t042_opcode", 64'(hs_op[0]), 64'h05);
    end

    // Back-pressure: ready low until the queue is full.
    lat_min = 0; lat_max = 1;
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("t043_req_low_full", 64'(last_req), 64'd0);
    checkOutput("t043_valid_full", 64'(last_valid), 64'd1);
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 16'h0, 1'($urandom_range(0, 1)));

    // PC and fetch-address wrap at the top of the address space.
    mem[16'hFFFF] = 8'h80; mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h00;
    clearLogs();
    applyStimulus(1'b1, 16'hFFFF, 1'b1);
    n = 0;
    while (hs_pc.size() < 2 && n < 40) begin applyStimulus(1'b0, 16'h0, 1'b1); n++; end
    checkOutput("t044_handshakes", 64'(hs_pc.size() >= 2), 64'd1);
    if (hs_pc.size() >= 2 && req_log.size() >= 2) begin
      checkOutput("t044_pc0", 64'(hs_pc[0]), 64'hFFFF);
      checkOutput("t044_len0", 64'(hs_len[0]), 64'd3);
      checkOutput("t044_imm0", 64'(hs_imm[0]), 64'h3412);
      checkOutput("t044_pc1", 64'(hs_pc[1]), 64'h0002);
      checkOutput("t044_req0", 64'(req_log[0]), 64'hFFFC);
      checkOutput("t044_req1", 64'(req_log[1]), 64'h0000);
    end

`ifdef INSTR_FETCH_PERF_EN
    // Seven starved cycles with ready high, then reset clears the counter.
    applyReset();
    ack_pct = 0;
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 16'h0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("t045_stall7", 64'(stall_count), 64'd7);
    ack_pct = 100;
`endif

    // Randomized traffic with redirects, back-pressure and variable latency.
    applyReset();
    ack_pct = 70; lat_min = 0; lat_max = 3;
    hs_total = 0;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) < 2), 16'($urandom), ($urandom_range(0, 3) != 0));
    end
    checkOutput("random_progress", 64'(hs_total > 200), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter WORD_WIDTH, default 32, SHALL set the data width of program memory reads and of the immediate output; it SHALL be a multiple of 8.
REQ-002 Parameter PROGRAM_ADDR_WIDTH, default 16, SHALL set the byte-address width of all program counters.
REQ-003 Parameter RESET_PC, default 0, SHALL set the byte address fetched first after reset.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit: the single clock.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port pm_req, output, 1 bit: program memory read request.
REQ-008 Port pm_addr, output, PROGRAM_ADDR_WIDTH bits: word-aligned byte address of the request.
REQ-009 Port pm_ack, input, 1 bit: memory accepts the request in this cycle.
REQ-010 Port pm_rvalid / pm_rdata, input, 1 / WORD_WIDTH bits: read response; byte 0 is in bits [7:0].
REQ-011 Port instr_valid / instr_ready, output / input, 1 bit each: instruction handshake.
REQ-012 Port instr_pc, output, PROGRAM_ADDR_WIDTH bits: byte address of the presented opcode.
REQ-013 Port opcode / imm, output, 8 / WORD_WIDTH bits: opcode byte and the bytes that follow it, little-endian and zero-filled.
REQ-014 Port instr_len, output, 4 bits: total instruction bytes (1, 2, 3, 5 or 1+WORD_WIDTH/8).
REQ-015 Port redirect / redirect_pc, input, 1 / PROGRAM_ADDR_WIDTH bits: flush the stream and restart at redirect_pc.

Function
REQ-016 A byte queue of QBYTES = 2*WORD_WIDTH/8 + 4 entries SHALL hold the fetched bytes in program order.
REQ-017 instr_valid SHALL be high exactly when the queue holds at least instr_len bytes.
REQ-018 instr_len SHALL be decoded combinationally from the queue head byte.
REQ-019 On instr_valid && instr_ready, the queue SHALL pop instr_len bytes, and instr_pc SHALL advance by instr_len with modulo-2^PROGRAM_ADDR_WIDTH wrap.
REQ-020 The FSM SHALL have three states:
  - S_IDLE: no read outstanding.
  - S_WAIT: one read outstanding.
  - S_DRAIN: one read outstanding whose response must be discarded.
REQ-021 In S_IDLE, pm_req SHALL be asserted when free space after this cycle's pop is at least WORD_WIDTH/8.
REQ-022 S_IDLE SHALL move to S_WAIT on pm_ack; pm_addr SHALL be held stable while pm_req is high and not yet acked.
REQ-023 S_WAIT SHALL return to S_IDLE on pm_rvalid, pushing the word's bytes.
REQ-024 A simultaneous pop and push SHALL both take effect in the same cycle.
REQ-025 After a redirect-restarted request, the push SHALL drop the first redirect_pc mod (WORD_WIDTH/8) bytes.
REQ-026 Each push SHALL advance the fetch address by WORD_WIDTH/8 with wrap.
REQ-027 redirect SHALL have priority over every other event in its cycle:
  - the queue empties and instr_valid is 0 in the next cycle;
  - instr_pc and the fetch address are loaded from redirect_pc (fetch address word-aligned);
  - any handshake in that cycle is ignored.
REQ-028 Redirect while in S_WAIT (no pm_rvalid that cycle) SHALL go to S_DRAIN; S_DRAIN SHALL go to S_IDLE on pm_rvalid, discarding the data.
REQ-029 Redirect in the same cycle as pm_rvalid SHALL discard that response and go to S_IDLE.
REQ-030 A pending, unacked pm_req SHALL drop in the redirect cycle and re-issue from the new address no earlier than the next cycle.
REQ-031 With instr_ready held high and memory returning every other cycle, throughput SHALL be at least one 1-byte instruction per cycle once the queue is primed.

Reset
REQ-032 Reset SHALL empty the queue, enter S_IDLE, and load instr_pc and the fetch address with RESET_PC.
REQ-033 After reset, pm_req, instr_valid, opcode, imm and instr_len SHALL all read 0.
REQ-034 Reset SHALL override a redirect or handshake in the same cycle.
REQ-035 A response arriving in the first cycle after reset SHALL be ignored.

Configuration
REQ-036 With macro INSTR_FETCH_PERF_EN defined, output stall_count (32 bits) SHALL increment every cycle in which instr_ready && !instr_valid && !redirect, saturate at all-ones, and clear on reset.
REQ-037 Without INSTR_FETCH_PERF_EN, the port and the counter logic SHALL be absent.

Structure
REQ-038 The fetch FSM state enum and the instruction-length constants (LEN_IMM0=1, LEN_IMM8=2, LEN_IMM16=3, LEN_IMM32=5) SHALL live in a shared package used by the core.
REQ-039 Opcode-to-length decoding SHALL be one sub-module, instr_length_decode, driven from the shared instruction-encoding macros.

Verification
REQ-040 Reset, RESET_PC=0, word 0 = {IMM8-class op, 0xAB, 1-byte op, x} -> first instr_pc=0, imm=0x000000AB, len=2; second instr_pc=2, len=1.
REQ-041 IMM32-class opcode at byte 3, queue empty -> instr_valid stays 0 until the second word is pushed; then imm spans both words and len=5.
REQ-042 redirect_pc=0x0006 while in S_WAIT -> stale response discarded; next pm_addr=0x0004; first instr_pc=0x0006 and opcode = byte 2 of that word.
REQ-043 instr_ready held low -> queue fills to QBYTES, pm_req stays low, and no byte is lost or duplicated after ready resumes.
REQ-044 instr_pc=0xFFFF (PROGRAM_ADDR_WIDTH=16) with a 3-byte instruction -> next instr_pc=0x0002 and pm_addr wraps to 0x0000.
REQ-045 With INSTR_FETCH_PERF_EN defined, 7 starved ready cycles -> stall_count=7; reset -> stall_count=0.
